// File: rtl/cmp_minmax_pkg.sv
// Shared types and defaults for the frame min/max tracker.
// Holds the FSM state encoding and the default WIDTH / FRAME_LEN.
package cmp_minmax_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/cmp_minmax_seq_if.sv
// Sample stream in, {max,min} result out, as one handshake bundle.
// master: producer/consumer side; slave: the tracker. MINMAX_IDX_EN adds idx.
interface cmp_minmax_seq_if
  import cmp_minmax_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
);
  localparam int IW = $clog2(FRAME_LEN);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
`ifdef MINMAX_IDX_EN
  logic [IW-1:0]    out_max_idx;
  logic [IW-1:0]    out_min_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid,
    input  out_max, out_min,
    input  out_max_idx, out_min_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid,
    output out_max, out_min,
    output out_max_idx, out_min_idx
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid,
    input  out_max, out_min
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid,
    output out_max, out_min
  );
`endif

endinterface

// File: rtl/cmp_minmax_seq_ge.sv
// Unsigned a >= b comparator, shared by the max and min tests.
// Ports: a, b (WIDTH) in; ge out.
module ge_comparator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge
);

  assign ge = (a >= b);

endmodule

// File: rtl/cmp_minmax_seq.sv
// Frame running max/min tracker, one shared comparator, 3 cycles/sample.
// Ports: clk, rst_n, flush, bus (slave). Macro MINMAX_IDX_EN adds indices.
module cmp_minmax_seq
  import cmp_minmax_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  cmp_minmax_seq_if.slave  bus
);

  localparam int CW = $clog2(FRAME_LEN);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef MINMAX_IDX_EN
  logic [CW-1:0]    max_idx;
  logic [CW-1:0]    min_idx;
`endif

  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             ge;
  logic             first;
  logic             last;

  // max test: sample >= max; min test: min >= sample.
  // Both are ">=", so ties move the index to the latest sample.
  always_comb begin
    cmp_a = sample_q;
    cmp_b = max_q;
    unique case (1'b1)
      (state == CMP_MIN): begin
        cmp_a = min_q;
        cmp_b = sample_q;
      end
      default: ;
    endcase
  end

  ge_comparator #(
    .WIDTH (WIDTH)
  ) u_ge (
    .a  (cmp_a),
    .b  (cmp_b),
    .ge (ge)
  );

  assign first = (count == '0);
  assign last  = (count == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCEPT;
      count       <= '0;
      sample_q    <= '0;
      max_q       <= '0;
      min_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MINMAX_IDX_EN
      max_idx     <= '0;
      min_idx     <= '0;
`endif
    end else if (flush) begin
      state       <= ACCEPT;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ACCEPT: begin
          if (bus.in_valid) begin
            sample_q   <= bus.in_data;
            in_ready_q <= 1'b0;
            state      <= CMP_MAX;
          end
        end
        CMP_MAX: begin
          if (first || ge) begin
            max_q   <= sample_q;
`ifdef MINMAX_IDX_EN
            max_idx <= count;
`endif
          end
          state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (first || ge) begin
            min_q   <= sample_q;
`ifdef MINMAX_IDX_EN
            min_idx <= count;
`endif
          end
          if (last) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            count      <= count + CW'(1);
            in_ready_q <= 1'b1;
            state      <= ACCEPT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            count       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ACCEPT;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = max_q;
  assign bus.out_min   = min_q;
`ifdef MINMAX_IDX_EN
  assign bus.out_max_idx = max_idx;
  assign bus.out_min_idx = min_idx;
`endif

endmodule
